countdown_ctrl: RTL and testbench

COUNTDOWN_CTRL -- requirements
Module: countdown_ctrl

---
 rtl/countdown_ctrl_if.sv | 22 ++
 rtl/countdown_ctrl.sv | 134 +++++++++++++
 tb/tb_countdown_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/countdown_ctrl_if.sv
// Control/data bundle between a host and the two-digit BCD countdown controller.
interface countdown_ctrl_if;
    logic       start;
    logic       pause;
    logic       clear;
    logic [3:0] load_tens;
    logic [3:0] load_ones;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [1:0] state;
    logic       done;

    modport master (
        output start, pause, clear, load_tens, load_ones,
        input  tens, ones, state, done
    );

    modport slave (
        input  start, pause, clear, load_tens, load_ones,
        output tens, ones, state, done
    );
endinterface

// File: rtl/countdown_ctrl.sv
// Two-digit BCD countdown timer with prescaler, pause/resume and clear.
// Optional feature: define AUTO_RELOAD_EN to reload from the captured start value on reaching 00.
module countdown_ctrl #(
    parameter int unsigned PRESCALE = 4
) (
    input logic             clk,
    input logic             rst_n,
    countdown_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [7:0] PRESC_LAST = 8'(PRESCALE - 1);

    state_t     state_r, state_s;
    logic [3:0] tens_r, tens_s, ones_r, ones_s;
    logic [3:0] rtens_r, rtens_s, rones_r, rones_s;
    logic [7:0] presc_r, presc_s;
    logic       done_r, done_s;
    logic [3:0] ld_tens_s, ld_ones_s, dec_tens_s, dec_ones_s;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    // Next-state, next-count and done-pulse decode; clear wins, then pause, tick, start
    always_comb begin
        state_s    = state_r;
        tens_s     = tens_r;
        ones_s     = ones_r;
        rtens_s    = rtens_r;
        rones_s    = rones_r;
        presc_s    = presc_r;
        done_s     = 1'b0;
        ld_tens_s  = clamp_digit(bus.load_tens);
        ld_ones_s  = clamp_digit(bus.load_ones);
        dec_ones_s = (ones_r == 4'd0) ? 4'd9 : (ones_r - 4'd1);
        dec_tens_s = (ones_r == 4'd0) ? (tens_r - 4'd1) : tens_r;
        if (bus.clear) begin
            state_s = ST_IDLE;
            tens_s  = 4'd0;
            ones_s  = 4'd0;
            presc_s = 8'd0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        rtens_s = ld_tens_s;
                        rones_s = ld_ones_s;
                        tens_s  = ld_tens_s;
                        ones_s  = ld_ones_s;
                        presc_s = 8'd0;
                        if ((ld_tens_s == 4'd0) && (ld_ones_s == 4'd0)) begin
                            state_s = ST_DONE;
                            done_s  = 1'b1;
                        end else begin
                            state_s = ST_RUN;
                        end
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_RUN: begin
                    if (bus.pause) begin
                        state_s = ST_PAUSE;
                    end else if (presc_r == PRESC_LAST) begin
                        presc_s = 8'd0;
                        tens_s  = dec_tens_s;
                        ones_s  = dec_ones_s;
                        if ((dec_tens_s == 4'd0) && (dec_ones_s == 4'd0)) begin
                            done_s = 1'b1;
`ifdef AUTO_RELOAD_EN
                            tens_s = rtens_r;
                            ones_s = rones_r;
`else
                            state_s = ST_DONE;
`endif
                        end else begin
                            done_s = 1'b0;
                        end
                    end else begin
                        presc_s = presc_r + 8'd1;
                    end
                end
                ST_PAUSE: begin
                    // Resume keeps the held prescaler phase; no reload here
                    if (bus.start) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_PAUSE;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    tens_s  = 4'd0;
                    ones_s  = 4'd0;
                    presc_s = 8'd0;
                end
            endcase
        end
    end

    // State, count, reload and done registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            tens_r  <= 4'd0;
            ones_r  <= 4'd0;
            rtens_r <= 4'd0;
            rones_r <= 4'd0;
            presc_r <= 8'd0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            tens_r  <= tens_s;
            ones_r  <= ones_s;
            rtens_r <= rtens_s;
            rones_r <= rones_s;
            presc_r <= presc_s;
            done_r  <= done_s;
        end
    end

    assign bus.tens  = tens_r;
    assign bus.ones  = ones_r;
    assign bus.state = state_r;
    assign bus.done  = done_r;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Self-checking bench for countdown_ctrl: vector table, corner sequences, random vs. reference model.
module tb_countdown_ctrl;

    localparam int P = 4;

    logic clk;
    logic rst_n;
    countdown_ctrl_if bus();

    countdown_ctrl #(.PRESCALE(P)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: value held as an integer 0..99, mode uses the output state code
    int m_mode, m_val, m_ph, m_rel, m_done;

    typedef struct {
        logic       s, p, c;
        logic [3:0] lt, lo;
        int         et, eo, es, ed;
    } vec_t;

    vec_t tbl[17];

    task automatic model_reset();
        m_mode = 0; m_val = 0; m_ph = 0; m_rel = 0; m_done = 0;
    endtask

    task automatic model_step(input logic s, input logic p, input logic c,
                              input logic [3:0] lt, input logic [3:0] lo);
        int v;
        m_done = 0;
        if (c) begin
            m_mode = 0; m_val = 0; m_ph = 0;
        end else if (m_mode == 0 || m_mode == 3) begin
            if (s) begin
                v = ((lt > 9) ? 9 : int'(lt)) * 10 + ((lo > 9) ? 9 : int'(lo));
                m_rel = v;
                m_ph  = 0;
                m_val = v;
                if (v == 0) begin m_mode = 3; m_done = 1; end
                else m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (p) m_mode = 2;
            else if (m_ph == P - 1) begin
                m_ph  = 0;
                m_val = m_val - 1;
                if (m_val == 0) begin
                    m_done = 1;
`ifdef AUTO_RELOAD_EN
                    m_val = m_rel;
`else
                    m_mode = 3;
`endif
                end
            end else m_ph = m_ph + 1;
        end else begin
            if (s) m_mode = 1;
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic chk_all(input string nm, input int et, input int eo, input int es, input int ed);
        chk({nm, ".tens"},  int'(bus.tens),  et);
        chk({nm, ".ones"},  int'(bus.ones),  eo);
        chk({nm, ".state"}, int'(bus.state), es);
        chk({nm, ".done"},  int'(bus.done),  ed);
    endtask

    task automatic chk_model(input string nm);
        chk_all(nm, m_val / 10, m_val % 10, m_mode, m_done);
    endtask

    task automatic cyc(input logic s, input logic p, input logic c,
                       input logic [3:0] lt, input logic [3:0] lo);
        bus.start = s; bus.pause = p; bus.clear = c;
        bus.load_tens = lt; bus.load_ones = lo;
        @(posedge clk);
        model_step(s, p, c, lt, lo);
        #1;
    endtask

    task automatic nop();
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    endtask

    initial begin
        int dcount;
        int exp_v;
        bus.start = 1'b0; bus.pause = 1'b0; bus.clear = 1'b0;
        bus.load_tens = 4'd0; bus.load_ones = 4'd0;
        rst_n = 1'b0;
        model_reset();
        #2;
        chk_all("reset", 0, 0, 0, 0);
        #10 rst_n = 1'b1;

        // Vector table: inputs for one cycle and the outputs expected after that edge
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 4'd0,  4'd0,  0, 0, 3, 1};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  0, 0, 3, 0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 4'hF,  4'hA,  9, 9, 1, 0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 4'd1,  4'd1,  9, 9, 1, 0};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 4'd5,  4'd5,  0, 0, 0, 0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 4'd0,  4'd1,  0, 1, 1, 0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  0, 1, 1, 0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  0, 1, 1, 0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  0, 1, 1, 0};
`ifdef AUTO_RELOAD_EN
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  0, 1, 1, 1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  0, 1, 1, 0};
`else
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  0, 0, 3, 1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  0, 0, 3, 0};
`endif
        tbl[11] = '{1'b0, 1'b0, 1'b1, 4'd0,  4'd0,  0, 0, 0, 0};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 4'd2,  4'd5,  2, 5, 1, 0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 4'd0,  4'd0,  2, 5, 2, 0};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 4'd0,  4'd0,  2, 5, 2, 0};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 4'd0,  4'd0,  2, 5, 1, 0};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 4'd0,  4'd0,  0, 0, 0, 0};
        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].s, tbl[i].p, tbl[i].c, tbl[i].lt, tbl[i].lo);
            chk_all($sformatf("vec%0d", i), tbl[i].et, tbl[i].eo, tbl[i].es, tbl[i].ed);
        end

        // Load 12: decrement every 4 cycles, done 48 cycles after start
        cyc(1'b1, 1'b0, 1'b0, 4'd1, 4'd2);
        chk_all("cnt12.k0", 1, 2, 1, 0);
        dcount = 0;
        for (int k = 1; k <= 49; k++) begin
            nop();
            if (k <= 47) dcount += int'(bus.done);
            if (k == 4)  chk_all("cnt12.k4", 1, 1, 1, 0);
            if (k == 8)  chk_all("cnt12.k8", 1, 0, 1, 0);
            if (k == 12) chk_all("cnt12.k12", 0, 9, 1, 0);
            if (k == 47) chk_all("cnt12.k47", 0, 1, 1, 0);
`ifdef AUTO_RELOAD_EN
            if (k == 48) chk_all("cnt12.k48", 1, 2, 1, 1);
            if (k == 49) chk_all("cnt12.k49", 1, 2, 1, 0);
`else
            if (k == 48) chk_all("cnt12.k48", 0, 0, 3, 1);
            if (k == 49) chk_all("cnt12.k49", 0, 0, 3, 0);
`endif
        end
        chk("cnt12.early_done", dcount, 0);

        // Load 30, pause while prescaler sits at 2, resume: 28 two cycles later
        cyc(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
        cyc(1'b1, 1'b0, 1'b0, 4'd3, 4'd0);
        for (int k = 1; k <= 6; k++) nop();
        chk_all("pz.pre", 2, 9, 1, 0);
        for (int k = 0; k < 10; k++) begin
            cyc(1'b0, (k == 0) ? 1'b1 : 1'(k % 2), 1'b0, 4'd0, 4'd0);
            chk_all($sformatf("pz.hold%0d", k), 2, 9, 2, 0);
        end
        cyc(1'b1, 1'b0, 1'b0, 4'd7, 4'd7);
        chk_all("pz.resume", 2, 9, 1, 0);
        nop();
        chk_all("pz.r1", 2, 9, 1, 0);
        nop();
        chk_all("pz.r2", 2, 8, 1, 0);

        // Clamped 99 then clear mid-count
        cyc(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
        cyc(1'b1, 1'b0, 1'b0, 4'hF, 4'hA);
        chk_all("clr.load", 9, 9, 1, 0);
        for (int k = 0; k < 5; k++) nop();
        cyc(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
        chk_all("clr.idle", 0, 0, 0, 0);
        nop();
        chk_all("clr.stay", 0, 0, 0, 0);

        // Asynchronous reset in the middle of a run
        cyc(1'b1, 1'b0, 1'b0, 4'd5, 4'd5);
        for (int k = 0; k < 6; k++) nop();
        #2 rst_n = 1'b0;
        model_reset();
        #1 chk_all("arst.now", 0, 0, 0, 0);
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            nop();
            chk_model($sformatf("arst.wait%0d", k));
        end
        chk_all("arst.idle", 0, 0, 0, 0);

`ifdef AUTO_RELOAD_EN
        // Auto reload from 02: 02,01,02,01 with done every 8 cycles
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 4'd2);
        for (int k = 1; k <= 24; k++) begin
            nop();
            exp_v = 2 - ((k / 4) % 2);
            chk_all($sformatf("ar.k%0d", k), 0, exp_v, 1, ((k % 8) == 0) ? 1 : 0);
        end
`endif

        // Random stimulus against the reference model
        for (int i = 0; i < 1500; i++) begin
            logic       rs, rp, rc;
            logic [3:0] rlt, rlo;
            rs  = ($urandom_range(0, 9) == 0);
            rp  = ($urandom_range(0, 15) == 0);
            rc  = ($urandom_range(0, 63) == 0);
            rlt = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
            rlo = 4'($urandom_range(0, 15));
            cyc(rs, rp, rc, rlt, rlo);
            chk_model($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
